// File: rtl/pwm_output_stage_pkg.sv
// Shared constants and the signed-to-offset-binary helper for the PWM output stage.
package pwm_output_stage_pkg;

  localparam int N_FRAC_DEFAULT = 7;
  localparam int W = N_FRAC_DEFAULT + 1;

  localparam logic [W-1:0] ONE       = W'('h7F);
  localparam logic [W-1:0] MINUS_ONE = W'('h81);
  localparam logic [W-1:0] ZERO      = W'('h00);

  // Flipping the sign bit maps -2^(w-1)..2^(w-1)-1 onto 0..2^w-1.
  function automatic logic [31:0] to_offset_binary(input logic [31:0] sample, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (sample ^ (32'd1 << (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/pwm_output_stage_prescaler.sv
// Clock divider producing one tick every PRESCALE clocks (every clock when PRESCALE=1).
module pwm_prescaler
  import pwm_output_stage_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = tick;

endmodule

// File: rtl/pwm_output_stage.sv
// Turns one signed sample per period into a PWM bit and requests the next sample each period.
// Optional sticky underrun_o output is enabled with `define PWM_UNDERRUN_FLAG_EN.
module pwm_output_stage
  import pwm_output_stage_pkg::*;
#(
  parameter int N_FRAC   = 7,
  parameter int PRESCALE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_FRAC:0] data_i,
  input  logic            data_in_valid_strobe_i,
  output logic            next_data_strobe_o,
  output logic            pwm_o,
`ifdef PWM_UNDERRUN_FLAG_EN
  output logic            underrun_o,
`endif
  output logic            period_start_o
);

  localparam int SW = N_FRAC + 1;
  localparam logic [SW-1:0] CNT_MAX = '1;

  // Strobe handshake: next_data_strobe_o is a one-clock request; upstream answers
  // with a one-clock data_in_valid_strobe_i, data_i is sampled only in that clock.
  logic          tick;
  logic          boundary;
  logic [SW-1:0] duty;

  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [SW-1:0] active_q, active_d;
  logic          pwm_q, pwm_d;
  logic          period_start_q, period_start_d;
  logic          next_strobe_q, next_strobe_d;
  logic          first_q, first_d;
`ifdef PWM_UNDERRUN_FLAG_EN
  logic          seen_q, seen_d;
  logic          underrun_q, underrun_d;
`endif

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  always_comb begin
    boundary       = tick && (cnt_q == CNT_MAX);
    cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
    shadow_d       = data_in_valid_strobe_i ? data_i : shadow_q;
    // Taking shadow_d gives the coincident-strobe bypass and the sample hold for free.
    active_d       = boundary ? shadow_d : active_q;
    duty           = SW'(to_offset_binary(32'(active_q), SW));
    pwm_d          = (cnt_q < duty);
    period_start_d = boundary;
    next_strobe_d  = boundary || first_q;
    first_d        = 1'b0;
`ifdef PWM_UNDERRUN_FLAG_EN
    seen_d         = boundary ? 1'b0 : (data_in_valid_strobe_i ? 1'b1 : seen_q);
    underrun_d     = underrun_q | (boundary & ~(seen_q | data_in_valid_strobe_i));
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      next_strobe_q  <= 1'b0;
      first_q        <= 1'b1;
`ifdef PWM_UNDERRUN_FLAG_EN
      seen_q         <= 1'b0;
      underrun_q     <= 1'b0;
`endif
    end else begin
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      next_strobe_q  <= next_strobe_d;
      first_q        <= first_d;
`ifdef PWM_UNDERRUN_FLAG_EN
      seen_q         <= seen_d;
      underrun_q     <= underrun_d;
`endif
    end
  end

  assign pwm_o              = pwm_q;
  assign period_start_o     = period_start_q;
  assign next_data_strobe_o = next_strobe_q;
`ifdef PWM_UNDERRUN_FLAG_EN
  assign underrun_o         = underrun_q;
`endif

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: PRESCALE=1 and PRESCALE=3 instances, per-period duty scoreboard.
module tb_pwm_output_stage;

  typedef struct {
    logic       s1_en;
    logic [7:0] s1;
    int         s1_pos;
    logic       s2_en;
    logic [7:0] s2;
    int         s2_pos;
    logic [7:0] exp_duty;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, stb_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       nds_a, pwm_a, ps_a, ur_a;
  logic       rst_b = 1'b0, stb_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       nds_b, pwm_b, ps_b, ur_b;

  pwm_output_stage #(.N_FRAC(7), .PRESCALE(1)) dut_a (
    .clk_i                 (clk),
    .rst_i                 (rst_a),
    .data_i                (data_a),
    .data_in_valid_strobe_i(stb_a),
    .next_data_strobe_o    (nds_a),
    .pwm_o                 (pwm_a),
`ifdef PWM_UNDERRUN_FLAG_EN
    .underrun_o            (ur_a),
`endif
    .period_start_o        (ps_a)
  );

  pwm_output_stage #(.N_FRAC(7), .PRESCALE(3)) dut_b (
    .clk_i                 (clk),
    .rst_i                 (rst_b),
    .data_i                (data_b),
    .data_in_valid_strobe_i(stb_b),
    .next_data_strobe_o    (nds_b),
    .pwm_o                 (pwm_b),
`ifdef PWM_UNDERRUN_FLAG_EN
    .underrun_o            (ur_b),
`endif
    .period_start_o        (ps_b)
  );

`ifndef PWM_UNDERRUN_FLAG_EN
  assign ur_a = 1'b0;
  assign ur_b = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         sel = 0;
  int         per = 256;
  int         presc = 1;
  int         pos = 0;
  logic [7:0] cur_duty = 8'd0;
  logic [7:0] pending_exp = 8'd128;
  logic       first_sample = 1'b0;
  logic       bench_seen = 1'b0;
  logic       exp_underrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0d, expected %0d (dut %0d, pos %0d, t=%0t)", name, act, exp, sel, pos, $time);
    end
  endtask

  task automatic monitor();
    logic p, ps, nds, ur;
    p   = (sel != 0) ? pwm_b : pwm_a;
    ps  = (sel != 0) ? ps_b  : ps_a;
    nds = (sel != 0) ? nds_b : nds_a;
    ur  = (sel != 0) ? ur_b  : ur_a;
    if (pos == 0) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 32'd1, 32'd0);
        cur_duty = 8'd0;
      end else begin
        cur_duty = exp_q.pop_front();
      end
    end
    check("pwm", 32'(p), 32'((pos / presc) < int'(cur_duty)));
    check("period_start", 32'(ps), 32'(pos == per - 1));
    check("next_req", 32'(nds), 32'((pos == per - 1) || first_sample));
    first_sample = 1'b0;
    if (pos == per - 1) begin
      if (!bench_seen) exp_underrun = 1'b1;
      bench_seen = 1'b0;
      exp_q.push_back(pending_exp);
    end
`ifdef PWM_UNDERRUN_FLAG_EN
    check("underrun", 32'(ur), 32'(exp_underrun));
`else
    if (ur !== 1'b0) check("underrun_tieoff", 32'(ur), 32'd0);
`endif
    pos = (pos == per - 1) ? 0 : pos + 1;
  endtask

  task automatic drive(input logic s, input logic [7:0] d);
    if (sel != 0) begin
      stb_b = s; data_b = d;
    end else begin
      stb_a = s; data_a = d;
    end
    if (s) bench_seen = 1'b1;
  endtask

  task automatic cycle(input logic s, input logic [7:0] d);
    @(negedge clk);
    monitor();
    drive(s, d);
  endtask

  // Strobes are held high during reset; they must leave no trace in shadow.
  task automatic do_reset(input int n);
    if (sel != 0) begin
      rst_b = 1'b0; stb_b = 1'b1; data_b = 8'h7F;
    end else begin
      rst_a = 1'b0; stb_a = 1'b1; data_a = 8'h7F;
    end
    repeat (n) begin
      @(negedge clk);
      check("rst_pwm", 32'((sel != 0) ? pwm_b : pwm_a), 32'd0);
      check("rst_period_start", 32'((sel != 0) ? ps_b : ps_a), 32'd0);
      check("rst_next_req", 32'((sel != 0) ? nds_b : nds_a), 32'd0);
      check("rst_underrun", 32'((sel != 0) ? ur_b : ur_a), 32'd0);
    end
    if (sel != 0) begin
      rst_b = 1'b1; stb_b = 1'b0; data_b = 8'h00;
    end else begin
      rst_a = 1'b1; stb_a = 1'b0; data_a = 8'h00;
    end
    pos = 0;
    exp_q.delete();
    exp_q.push_back(8'd128);
    pending_exp  = 8'd128;
    first_sample = 1'b1;
    bench_seen   = 1'b0;
    exp_underrun = 1'b0;
  endtask

  task automatic run_window(input vec_t v);
    logic       s;
    logic [7:0] d;
    pending_exp = v.exp_duty;
    for (int c = 0; c < per; c++) begin
      s = 1'b0;
      d = 8'h00;
      if (v.s2_en && c == v.s2_pos) begin
        s = 1'b1; d = v.s2;
      end else if (v.s1_en && c == v.s1_pos) begin
        s = 1'b1; d = v.s1;
      end
      cycle(s, d);
    end
  endtask

  vec_t tbl_a[14];
  vec_t tbl_b[5];
  vec_t v;

  initial begin
    tbl_a[0]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd128};
    tbl_a[1]  = '{1'b1, 8'h7F,   3, 1'b0, 8'h00,   0, 8'd255};
    tbl_a[2]  = '{1'b1, 8'h81,   3, 1'b0, 8'h00,   0, 8'd1};
    tbl_a[3]  = '{1'b1, 8'h80, 200, 1'b0, 8'h00,   0, 8'd0};
    tbl_a[4]  = '{1'b1, 8'h7F, 254, 1'b0, 8'h00,   0, 8'd255};
    tbl_a[5]  = '{1'b1, 8'h40,   5, 1'b1, 8'hC0, 100, 8'd64};
    tbl_a[6]  = '{1'b1, 8'h40,   7, 1'b0, 8'h00,   0, 8'd192};
    tbl_a[7]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd192};
    tbl_a[8]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd192};
    tbl_a[9]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd192};
    tbl_a[10] = '{1'b1, 8'h01, 254, 1'b0, 8'h00,   0, 8'd129};
    tbl_a[11] = '{1'b1, 8'hFF,   0, 1'b0, 8'h00,   0, 8'd127};
    tbl_a[12] = '{1'b1, 8'h00, 128, 1'b0, 8'h00,   0, 8'd128};
    tbl_a[13] = '{1'b1, 8'h40,   3, 1'b0, 8'h00,   0, 8'd192};

    tbl_b[0]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd128};
    tbl_b[1]  = '{1'b1, 8'h81,  10, 1'b0, 8'h00,   0, 8'd1};
    tbl_b[2]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd1};
    tbl_b[3]  = '{1'b1, 8'h7F, 766, 1'b0, 8'h00,   0, 8'd255};
    tbl_b[4]  = '{1'b0, 8'h00,   0, 1'b0, 8'h00,   0, 8'd255};

    // PRESCALE=1 instance
    sel = 0; per = 256; presc = 1;
    do_reset(3);
    for (int i = 0; i < 14; i++) run_window(tbl_a[i]);

    for (int i = 0; i < 3; i++) begin
      v.s1_en    = 1'b1;
      v.s1       = 8'($urandom_range(0, 255));
      v.s1_pos   = int'($urandom_range(0, 254));
      v.s2_en    = 1'b0;
      v.s2       = 8'h00;
      v.s2_pos   = 0;
      v.exp_duty = v.s1 ^ 8'h80;
      run_window(v);
    end
    run_window(tbl_a[13]);
    v = tbl_a[13];
    v.s1_en = 1'b0;
    run_window(v);

    // Abort mid-period while pwm_o is high, then replay the reset-release scenario.
    repeat (10) cycle(1'b0, 8'h00);
    check("pwm_high_before_abort", 32'(pwm_a), 32'd1);
    do_reset(2);
    run_window(tbl_a[0]);
    run_window(tbl_a[0]);

    // PRESCALE=3 instance
    sel = 1; per = 768; presc = 3;
    do_reset(2);
    for (int i = 0; i < 5; i++) run_window(tbl_b[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
